// File: rtl/shiftadd_mul_arbiter_pkg.sv
// Shared definitions for the shared shift-add multiplier and its arbiter:
// FSM state encoding, the default operand width, the step counter width
// and the round-robin winner search.
package shiftadd_mul_arbiter_pkg;

    // Two-state sequencer: waiting for a request, or stepping the datapath.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Default operand width.
    localparam int N_DEFAULT = 8;

    // Largest requester count the winner search handles.
    localparam int MAX_REQS = 16;

    // Width of a counter that runs 0..n-1. It is kept at 1 bit or more, so
    // the counter still has a bit when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Round-robin search. It returns the first set bit of req, looking
    // upward from ptr and wrapping modulo reqs. The caller only uses the
    // result when req is non-zero.
    function automatic logic [3:0] rr_winner(
        input logic [MAX_REQS-1:0] req,
        input logic [3:0]          ptr,
        input int                  reqs
    );
        logic [3:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQS; i++) begin
            idx = (int'(ptr) + i) % reqs;
            if (!found && (i < reqs) && req[idx[3:0]]) begin
                win   = idx[3:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/shiftadd_mul_core.sv
// Shift-add multiplier datapath. The load input clears the accumulator
// and captures the operands. Each step input adds the shifted
// multiplicand when the current multiplier LSB is set, then shifts both
// operands by one position.
module shiftadd_mul_core #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   mcand_in,
    input  logic [N-1:0]   mplier_in,
    output logic [2*N-1:0] acc,
    output logic           lsb
);

    logic [2*N-1:0] acc_reg;
    logic [2*N-1:0] mcand_reg;
    logic [N-1:0]   mplier_reg;

    // Load the operands, or perform one conditional add and shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (load) begin
            acc_reg    <= '0;
            mcand_reg  <= {{N{1'b0}}, mcand_in};
            mplier_reg <= mplier_in;
        end else if (step) begin
            if (mplier_reg[0]) begin
                acc_reg <= acc_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
        end
    end

    assign acc = acc_reg;
    assign lsb = mplier_reg[0];

endmodule

// File: rtl/shiftadd_mul_arbiter.sv
// Round-robin front end for one shared shift-add multiplier.
// In IDLE it picks a requester and loads that requester's operands.
// In RUN it steps the datapath for exactly N cycles. It then pulses done
// and tags the 2N-bit product with the owner's index.
module shiftadd_mul_arbiter
    import shiftadd_mul_arbiter_pkg::*;
#(
    parameter int N    = N_DEFAULT,
    parameter int REQS = 4,
    parameter int ID_W = $clog2(REQS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQS-1:0]   req,
    input  logic [REQS*N-1:0] a_in,
    input  logic [REQS*N-1:0] b_in,
    output logic [REQS-1:0]   gnt,
    output logic              busy,
    output logic              done,
    output logic [ID_W-1:0]   done_id,
    output logic [2*N-1:0]    product
);

    localparam int CNT_W = cnt_width(N);

    state_t          state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0] id_reg, id_next;
    logic [REQS-1:0] gnt_reg, gnt_next;
    logic            done_reg, done_next;
    logic [ID_W-1:0] done_id_reg, done_id_next;
    logic [2*N-1:0]  product_hold_reg;

    logic            load;
    logic            step;
    logic [ID_W-1:0] win;
    logic [N-1:0]    mcand_sel;
    logic [N-1:0]    mplier_sel;
    logic [2*N-1:0]  acc;
    logic            core_lsb;

    // Round-robin winner among the current requests.
    assign win = ID_W'(rr_winner(MAX_REQS'(req), 4'(rr_ptr_reg), REQS));

    // Operands of the winner, taken from the packed input buses.
    assign mcand_sel  = a_in[win*N +: N];
    assign mplier_sel = b_in[win*N +: N];

    shiftadd_mul_core #(
        .N (N)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .mcand_in  (mcand_sel),
        .mplier_in (mplier_sel),
        .acc       (acc),
        .lsb       (core_lsb)
    );

    // Next-state, grant, completion and pointer logic.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rr_ptr_next  = rr_ptr_reg;
        id_next      = id_reg;
        gnt_next     = '0;
        done_next    = 1'b0;
        done_id_next = done_id_reg;
        load         = 1'b0;
        step         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|req) begin
                    gnt_next   = {{(REQS-1){1'b0}}, 1'b1} << win;
                    load       = 1'b1;
                    cnt_next   = '0;
                    id_next    = win;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step     = 1'b1;
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(N - 1)) begin
                    cnt_next     = '0;
                    done_next    = 1'b1;
                    done_id_next = id_reg;
                    rr_ptr_next  = (id_reg == ID_W'(REQS - 1)) ? '0 : id_reg + 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, counter, pointer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            rr_ptr_reg  <= '0;
            id_reg      <= '0;
            gnt_reg     <= '0;
            done_reg    <= 1'b0;
            done_id_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rr_ptr_reg  <= rr_ptr_next;
            id_reg      <= id_next;
            gnt_reg     <= gnt_next;
            done_reg    <= done_next;
            done_id_reg <= done_id_next;
        end
    end

    // Keep the finished product after the done cycle. The next load clears
    // the accumulator, but that happens no earlier than this capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            product_hold_reg <= '0;
        end else if (done_reg) begin
            product_hold_reg <= acc;
        end
    end

    // The accumulator holds the final sum during the done cycle. After
    // that cycle the held copy drives the output.
    assign product = done_reg ? acc : product_hold_reg;
    assign gnt     = gnt_reg;
    assign busy    = (state_reg == ST_RUN);
    assign done    = done_reg;
    assign done_id = done_id_reg;

    // The multiplier LSB is not needed here: every operation runs the full
    // N steps, even when the remaining multiplier bits are all zero.
    logic unused_ok;
    assign unused_ok = core_lsb;

endmodule

// File: tb/tb_shiftadd_mul_arbiter.sv
// Directed testbench for shiftadd_mul_arbiter (N=8, REQS=4).
module tb_shiftadd_mul_arbiter;

    localparam int N    = 8;
    localparam int REQS = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [REQS-1:0]   req;
    logic [REQS*N-1:0] a_in;
    logic [REQS*N-1:0] b_in;
    logic [REQS-1:0]   gnt;
    logic              busy;
    logic              done;
    logic [ID_W-1:0]   done_id;
    logic [2*N-1:0]    product;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_now  = 0;

    shiftadd_mul_arbiter #(
        .N    (N),
        .REQS (REQS),
        .ID_W (ID_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_now++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_op(input int idx, input logic [N-1:0] a, input logic [N-1:0] b);
        a_in[idx*N +: N] = a;
        b_in[idx*N +: N] = b;
    endtask

    task automatic wait_gnt(input string tag);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while ((gnt == '0) && (c < 40));
        if (gnt == '0) check({tag, "_gnt_timeout"}, 32'(|gnt), 32'd1);
    endtask

    task automatic wait_done(input string tag, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        do begin
            tick();
            lat++;
            if (busy && !done) busy_cnt++;
        end while (!done && (lat < 40));
        if (!done) check({tag, "_done_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic run_single(input string tag, input int idx, input logic [N-1:0] a,
                              input logic [N-1:0] b, input int exp_prod);
        int lat, bc;
        set_op(idx, a, b);
        req = 4'b0001 << idx;
        wait_gnt(tag);
        check({tag, "_gnt"}, 32'(gnt), 32'(4'b0001 << idx));
        check({tag, "_busy_at_gnt"}, 32'(busy), 32'd1);
        req = '0;
        wait_done(tag, lat, bc);
        $display("%s: idx=%0d a=%0d b=%0d product=%0d done_id=%0d latency=%0d", tag, idx, a, b, product, done_id, lat);
        check({tag, "_latency"}, 32'(lat), 32'd8);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd7);
        check({tag, "_product"}, 32'(product), 32'(exp_prod));
        check({tag, "_done_id"}, 32'(done_id), 32'(idx));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_product_held"}, 32'(product), 32'(exp_prod));
    endtask

    // Global bound in case the DUT never responds.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc, t_prev, cnt;
        int exp_idx;
        int prod_tab [4];
        prod_tab = '{3, 8, 15, 24};

        // Reset state.
        reset = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        reset = 1'b1;
        tick();

        // Test 1: 13*11.
        run_single("t1", 0, 8'd13, 8'd11, 143);

        // Test 2: max operands, then a zero multiplicand that still takes N cycles.
        run_single("t2a", 0, 8'd255, 8'd255, 65025);
        run_single("t2b", 0, 8'd0, 8'd200, 0);

        // Test 3: requesters 0 and 2 held from reset.
        reset = 1'b0;
        set_op(0, 8'd7, 8'd9);
        set_op(2, 8'd20, 8'd30);
        req = 4'b0101;
        tick();
        reset = 1'b1;
        wait_gnt("t3a");
        check("t3_gnt_first", 32'(gnt), 32'b0001);
        wait_done("t3a", lat, bc);
        $display("t3a: product=%0d done_id=%0d latency=%0d", product, done_id, lat);
        check("t3_lat_first", 32'(lat), 32'd8);
        check("t3_prod_first", 32'(product), 32'd63);
        check("t3_id_first", 32'(done_id), 32'd0);
        tick();
        check("t3_gnt_second", 32'(gnt), 32'b0100);
        req = '0;
        wait_done("t3b", lat, bc);
        $display("t3b: product=%0d done_id=%0d latency=%0d", product, done_id, lat);
        check("t3_lat_second", 32'(lat), 32'd8);
        check("t3_prod_second", 32'(product), 32'd600);
        check("t3_id_second", 32'(done_id), 32'd2);

        // Test 4: all four requesting continuously for five operations.
        reset = 1'b0;
        for (int i = 0; i < REQS; i++) set_op(i, 8'(i + 1), 8'(i + 3));
        req = 4'b1111;
        tick();
        reset  = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            exp_idx = k % REQS;
            wait_gnt("t4");
            $display("t4: op=%0d gnt=%b cycle=%0d", k, gnt, cyc_now);
            check("t4_gnt_order", 32'(gnt), 32'(4'b0001 << exp_idx));
            if (k > 0) check("t4_gnt_spacing", 32'(cyc_now - t_prev), 32'd9);
            t_prev = cyc_now;
            if (k == 4) req = '0;
            wait_done("t4", lat, bc);
            check("t4_product", 32'(product), 32'(prod_tab[exp_idx]));
            check("t4_done_id", 32'(done_id), 32'(exp_idx));
        end

        // Test 5: move the pointer to 3, then abort an operation with reset.
        run_single("t5pre", 2, 8'd6, 8'd7, 42);
        set_op(3, 8'd5, 8'd6);
        req = 4'b1000;
        wait_gnt("t5");
        check("t5_gnt_pre", 32'(gnt), 32'b1000);
        req = '0;
        tick();
        tick();
        tick();
        reset = 1'b0;
        #1;
        $display("t5: reset mid-RUN busy=%0d done=%0d product=%0d", busy, done, product);
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_product", 32'(product), 32'd0);
        check("t5_abort_done", 32'(done), 32'd0);
        cnt = 0;
        tick();
        if (done) cnt++;
        tick();
        if (done) cnt++;
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) cnt++;
        end
        check("t5_no_done", 32'(cnt), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        set_op(1, 8'd3, 8'd4);
        set_op(3, 8'd9, 8'd9);
        req = 4'b1010;
        wait_gnt("t5post");
        check("t5_gnt_after_reset", 32'(gnt), 32'b0010);
        req = '0;
        wait_done("t5post", lat, bc);
        $display("t5post: product=%0d done_id=%0d", product, done_id);
        check("t5_prod_after", 32'(product), 32'd12);
        check("t5_id_after", 32'(done_id), 32'd1);

        // Test 6: a request pulse during RUN is ignored; operands are sampled at grant.
        set_op(0, 8'd9, 8'd10);
        req = 4'b0001;
        wait_gnt("t6");
        check("t6_gnt", 32'(gnt), 32'b0001);
        set_op(0, 8'd1, 8'd1);
        req = 4'b0100;
        tick();
        req = '0;
        wait_done("t6", lat, bc);
        $display("t6: product=%0d done_id=%0d latency=%0d", product, done_id, lat);
        check("t6_lat", 32'(lat), 32'd7);
        check("t6_product", 32'(product), 32'd90);
        check("t6_done_id", 32'(done_id), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (gnt != '0) cnt++;
        end
        check("t6_no_grant", 32'(cnt), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
